// File: rtl/fifo_access_scheduler.sv
// Arbitrates N producers and one consumer onto a single-port-per-cycle FIFO.
// Writes rotate round-robin; write/read contention alternates every MAX_BURST grants.
module fifo_access_scheduler #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]     i_req_data,
    output logic [NUM_REQ-1:0]            o_req_ack,
    input  logic                          i_cons_req,
    output logic                          o_cons_ack,
    output logic [DATA_W-1:0]             o_cons_data,
    output logic                          o_fifo_wrt_en,
    output logic                          o_fifo_rd_en,
    output logic [DATA_W-1:0]             o_fifo_data_in,
    input  logic [DATA_W-1:0]             i_fifo_data_out,
    input  logic                          i_fifo_full,
    input  logic                          i_fifo_empty,
    output logic [$clog2(DEPTH+1)-1:0]    o_fifo_level
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    typedef enum logic {PriWr = 1'b0, PriRd = 1'b1} pri_e;

    pri_e             r_pri, w_pri_nxt;
    logic [3:0]       r_cnt, w_cnt_nxt;
    logic [PTR_W-1:0] r_rr_ptr, w_rr_nxt, w_idx;
    logic [LVL_W-1:0] r_level, w_level_nxt;
    logic             w_found;
    logic             w_wr_cand, w_rd_cand, w_contend;
    logic             w_grant_wr, w_grant_rd;

    assign w_wr_cand  = (|i_req_valid) & ~i_fifo_full;
    assign w_rd_cand  = i_cons_req & ~i_fifo_empty;
    assign w_contend  = w_wr_cand & w_rd_cand;
    // Grants are masked by rst_n so nothing reaches the FIFO while it is being reset.
    assign w_grant_wr = rst_n & w_wr_cand & (~w_rd_cand | (r_pri == PriWr));
    assign w_grant_rd = rst_n & w_rd_cand & ~w_grant_wr;

    // First valid requester at or after r_rr_ptr, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            int unsigned j;
            j = (32'(r_rr_ptr) + k) % NUM_REQ;
            if (!w_found && i_req_valid[j]) begin
                w_found = 1'b1;
                w_idx   = PTR_W'(j);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pri    <= PriWr;
            r_cnt    <= '0;
            r_rr_ptr <= '0;
            r_level  <= '0;
        end else begin
            r_pri    <= w_pri_nxt;
            r_cnt    <= w_cnt_nxt;
            r_rr_ptr <= w_rr_nxt;
            r_level  <= w_level_nxt;
        end
    end

    always_comb begin
        w_pri_nxt   = r_pri;
        w_cnt_nxt   = r_cnt;
        w_rr_nxt    = r_rr_ptr;
        w_level_nxt = r_level;
        if (w_contend) begin
            if (r_cnt == 4'(MAX_BURST - 1)) begin
                w_cnt_nxt = '0;
                w_pri_nxt = (r_pri == PriWr) ? PriRd : PriWr;
            end else begin
                w_cnt_nxt = r_cnt + 4'd1;
            end
        end
        if (w_grant_wr) begin
            w_rr_nxt    = (w_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_idx + PTR_W'(1);
            w_level_nxt = r_level + LVL_W'(1);
        end else if (w_grant_rd) begin
            w_level_nxt = r_level - LVL_W'(1);
        end
    end

    always_comb begin
        o_req_ack      = '0;
        o_fifo_data_in = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_grant_wr && (w_idx == PTR_W'(i))) begin
                o_req_ack[i]   = 1'b1;
                o_fifo_data_in = i_req_data[i*DATA_W +: DATA_W];
            end
        end
        o_fifo_wrt_en = w_grant_wr;
        o_fifo_rd_en  = w_grant_rd;
        o_cons_ack    = w_grant_rd;
    end

    assign o_cons_data  = i_fifo_data_out;
    assign o_fifo_level = r_level;

`ifndef SYNTHESIS
    a_level_range: assert property (@(posedge clk) disable iff (!rst_n)
        r_level <= LVL_W'(DEPTH));
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_grant_wr && (r_level == LVL_W'(DEPTH))));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_grant_rd && (r_level == '0)));
    a_full_match: assert property (@(posedge clk) disable iff (!rst_n)
        i_fifo_full == (r_level == LVL_W'(DEPTH)));
    a_empty_match: assert property (@(posedge clk) disable iff (!rst_n)
        i_fifo_empty == (r_level == '0));
    a_excl: assert property (@(posedge clk) !(o_fifo_wrt_en && o_fifo_rd_en));
    a_onehot: assert property (@(posedge clk) $onehot0(o_req_ack));
`endif

endmodule

// File: tb/tb_fifo_access_scheduler.sv
// Bench for fifo_access_scheduler: external FWFT FIFO stand-in, a queue-based
// reference model checked every cycle, and directed phases with literal expectations.
module tb_fifo_access_scheduler;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 16;
    localparam int unsigned D  = 8;
    localparam int unsigned MB = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ack;
    logic           cons_req, cons_ack;
    logic [W-1:0]   cons_data;
    logic           fifo_wrt_en, fifo_rd_en;
    logic [W-1:0]   fifo_data_in, fifo_data_out;
    logic           fifo_full, fifo_empty;
    logic [3:0]     fifo_level;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_access_scheduler #(
        .NUM_REQ(N), .DATA_W(W), .DEPTH(D), .MAX_BURST(MB)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_req_valid    (req_valid),
        .i_req_data     (req_data),
        .o_req_ack      (req_ack),
        .i_cons_req     (cons_req),
        .o_cons_ack     (cons_ack),
        .o_cons_data    (cons_data),
        .o_fifo_wrt_en  (fifo_wrt_en),
        .o_fifo_rd_en   (fifo_rd_en),
        .o_fifo_data_in (fifo_data_in),
        .i_fifo_data_out(fifo_data_out),
        .i_fifo_full    (fifo_full),
        .i_fifo_empty   (fifo_empty),
        .o_fifo_level   (fifo_level)
    );

    // External FIFO stand-in, sharing rst_n with the scheduler.
    logic [W-1:0] fmem [D];
    logic [2:0]   fwp, frp;
    logic [3:0]   fcnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwp <= '0; frp <= '0; fcnt <= '0;
        end else if (fifo_wrt_en) begin
            fmem[fwp] <= fifo_data_in;
            fwp <= fwp + 3'd1;
            fcnt <= fcnt + 4'd1;
        end else if (fifo_rd_en) begin
            frp <= frp + 3'd1;
            fcnt <= fcnt - 4'd1;
        end
    end
    assign fifo_data_out = fmem[frp];
    assign fifo_full     = (fcnt == 4'(D));
    assign fifo_empty    = (fcnt == 4'd0);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: contents as a queue, grant rules evaluated directly.
    logic [W-1:0] sb[$];
    int unsigned  m_rr;
    bit           m_pri_rd;
    int unsigned  m_cnt;
    bit           wc, rc, p_wr, p_rd;
    int           p_idx;
    logic [W-1:0] p_din;
    logic [N-1:0] e_ack;

    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            m_rr = 0; m_pri_rd = 0; m_cnt = 0;
            wc = 0; rc = 0; p_wr = 0; p_rd = 0; p_idx = -1; p_din = '0;
        end else begin
            wc = (req_valid != '0) && (sb.size() < D);
            rc = cons_req && (sb.size() > 0);
            p_wr = wc && (!rc || !m_pri_rd);
            p_rd = rc && !p_wr;
            p_idx = -1;
            for (int k = 0; k < N; k++) begin
                int j;
                j = (int'(m_rr) + k) % N;
                if (p_idx < 0 && req_valid[j]) p_idx = j;
            end
            p_din = (p_wr && p_idx >= 0) ? req_data[p_idx*W +: W] : '0;
        end
        e_ack = '0;
        if (p_wr && p_idx >= 0) e_ack[p_idx] = 1'b1;
        chk("m_req_ack", 64'(req_ack), 64'(e_ack));
        chk("m_wrt_en", 64'(fifo_wrt_en), 64'(p_wr));
        chk("m_rd_en", 64'(fifo_rd_en), 64'(p_rd));
        chk("m_cons_ack", 64'(cons_ack), 64'(p_rd));
        chk("m_data_in", 64'(fifo_data_in), 64'(p_din));
        chk("m_level", 64'(fifo_level), 64'(sb.size()));
        if (p_rd) chk("m_cons_data", 64'(cons_data), 64'(sb[0]));
    end

    always @(posedge clk) begin
        if (rst_n) begin
            if (wc && rc) begin
                m_cnt++;
                if (m_cnt == MB) begin
                    m_cnt = 0;
                    m_pri_rd = !m_pri_rd;
                end
            end
            if (p_wr) begin
                sb.push_back(p_din);
                m_rr = (int'(p_idx) + 1) % N;
            end else if (p_rd) begin
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] exp_v;
        logic         exp_w;
        rst_n = 1'b0; req_valid = '0; req_data = '0; cons_req = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_grants", 64'({req_ack, cons_ack, fifo_wrt_en, fifo_rd_en}), 64'd0);
        chk("reset_level", 64'(fifo_level), 64'd0);

        // Round-robin fill to full.
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) req_data[i*W +: W] = 16'hA000 + 16'(i);
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            exp_v = 4'b0001 << (k % 4);
            chk("rr_ack", 64'(req_ack), 64'(exp_v));
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("full_no_ack", 64'(req_ack), 64'd0);
        chk("full_level", 64'(fifo_level), 64'd8);
        chk("full_flag", 64'(fifo_full), 64'd1);

        // Full boundary: read first, then producer 2 refills.
        @(posedge clk); #1;
        req_valid = 4'b0100; cons_req = 1'b1;
        @(negedge clk);
        chk("fb_read", 64'(cons_ack), 64'd1);
        chk("fb_read_data", 64'(cons_data), 64'hA000);
        chk("fb_no_wr", 64'(req_ack), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("fb_level7", 64'(fifo_level), 64'd7);
        chk("fb_wr_ack", 64'(req_ack), 64'b0100);
        @(posedge clk); #1;
        req_valid = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("drain_data", 64'(cons_data), 64'(16'hA001 + 16'(k)));
            @(posedge clk); #1;
        end

        // Reset mid-burst at level 5.
        req_valid = 4'hF; cons_req = 1'b1;
        @(negedge clk);
        chk("mid_level5", 64'(fifo_level), 64'd5);
        chk("mid_active", 64'(fifo_wrt_en | fifo_rd_en), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_grants_drop", 64'({req_ack, cons_ack, fifo_wrt_en, fifo_rd_en}), 64'd0);
        chk("rst_level", 64'(fifo_level), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1; cons_req = 1'b0;
        @(negedge clk);
        chk("post_rst_level", 64'(fifo_level), 64'd0);
        chk("post_rst_first", 64'(req_ack), 64'b0001);
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_rst_second", 64'(req_ack), 64'b0010);
        @(posedge clk); #1;

        // Contention at level 2: 4 writes, 4 reads, 4 writes.
        req_valid = 4'b0001; cons_req = 1'b1;
        for (int k = 0; k < 12; k++) begin
            req_data[0 +: W] = 16'hB000 + 16'(k);
            @(negedge clk);
            exp_w = (k < 4) || (k >= 8);
            chk("cont_wr", 64'(fifo_wrt_en), 64'(exp_w));
            chk("cont_rd", 64'(fifo_rd_en), 64'(!exp_w));
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("cont_level", 64'(fifo_level), 64'd6);
        @(posedge clk); #1;

        // Random mix of producers and consumer, then drain.
        for (int k = 0; k < 40; k++) begin
            req_valid = 4'($urandom_range(0, 15));
            cons_req  = 1'($urandom_range(0, 1));
            for (int i = 0; i < N; i++)
                req_data[i*W +: W] = 16'hA000 + 16'((k % 16) << 4) + 16'(i);
            @(posedge clk); #1;
        end
        req_valid = '0; cons_req = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        @(negedge clk);
        chk("end_level", 64'(fifo_level), 64'd0);
        chk("end_empty", 64'(fifo_empty), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
